// File: rtl/uwire_pkg.sv
// Shared definitions for the uWire receiver: word geometry, FSM states and
// a small saturating-counter helper.
package uwire_pkg;

  localparam int UWIRE_WORD_W = 32;
  localparam int UWIRE_ADDR_W = 5;
  localparam int UWIRE_DATA_W = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    LE_HIGH = 2'd3
  } uwire_state_e;

  // Bit counter increment that sticks at 63 so oversize frames stay "wrong".
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'd63) begin
      r = v;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uwire_pin_sync.sv
// N-stage synchronizer for one asynchronous uWire pin, followed by one extra
// flop used to derive single-cycle rise/fall strobes in the clk domain.
module uwire_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchronizer chain plus the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{1'b0}};
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/uwire_receiver.sv
// uWire serial receiver: shifts 32-bit MSB-first frames, latches them on LE,
// and presents the word through a valid/ready handshake with error strobes.
// Optional feature: define UWIRE_RX_REGFILE_EN to add a 32x27 shadow register
// file (rd_addr / rd_data / written ports).
module uwire_receiver
  import uwire_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CLKuWire,
  input  logic             DATAuWire,
  input  logic             LEuWire,
  output logic [31:0]      q,
  output logic [4:0]       addr,
  output logic [26:0]      data,
  output logic             valid,
  input  logic             ready,
  output logic             err_len,
  output logic             err_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
`ifdef UWIRE_RX_REGFILE_EN
  ,
  input  logic [4:0]       rd_addr,
  output logic [26:0]      rd_data,
  output logic [31:0]      written
`endif
);

  localparam logic [5:0] FULL_CNT = 6'(UWIRE_WORD_W);

  uwire_state_e state;
  logic [31:0]  shreg;
  logic [5:0]   bit_cnt;
  logic         accept;

  logic clk_lvl, clk_rise, clk_fall;
  logic dat_lvl, dat_rise, dat_fall;
  logic le_lvl,  le_rise,  le_fall;
  logic unused_edges;

  uwire_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin(CLKuWire),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  uwire_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .pin(DATAuWire),
    .level(dat_lvl), .rise(dat_rise), .fall(dat_fall)
  );

  uwire_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .pin(LEuWire),
    .level(le_lvl), .rise(le_rise), .fall(le_fall)
  );

  // Data edges and the serial clock fall carry no meaning for the protocol.
  assign unused_edges = ^{clk_lvl, clk_fall, dat_rise, dat_fall};

  // A complete word is taken when the output slot is free or being drained.
  assign accept = (state == LATCH) && (bit_cnt == FULL_CNT) && (!valid || ready);

  assign addr = q[4:0];
  assign data = q[31:5];

  // Receiver FSM with shift register, output word, handshake and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= 32'h0000_0000;
      bit_cnt  <= 6'd0;
      q        <= 32'h0000_0000;
      valid    <= 1'b0;
      err_len  <= 1'b0;
      err_ovf  <= 1'b0;
      busy     <= 1'b0;
      word_cnt <= {CNT_W{1'b0}};
    end else begin
      err_len <= 1'b0;
      err_ovf <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A coincident LE rise still takes the bit before latching.
          if (clk_rise && (!le_lvl || le_rise)) begin
            shreg   <= {shreg[30:0], dat_lvl};
            bit_cnt <= 6'd1;
          end
          if (le_rise) begin
            state <= LATCH;
            busy  <= 1'b1;
          end else if (clk_rise && !le_lvl) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg   <= {shreg[30:0], dat_lvl};
            bit_cnt <= sat_inc6(bit_cnt);
          end
          if (le_rise) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          state   <= LE_HIGH;
          bit_cnt <= 6'd0;
          if (bit_cnt != FULL_CNT) begin
            err_len <= 1'b1;
          end else if (accept) begin
            q        <= shreg;
            valid    <= 1'b1;
            word_cnt <= word_cnt + CNT_W'(1);
          end else begin
            err_ovf <= 1'b1;
          end
        end
        LE_HIGH: begin
          if (le_fall) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= 6'd0;
        end
      endcase
    end
  end

`ifdef UWIRE_RX_REGFILE_EN
  logic [26:0] regfile [32];

  // Shadow copy of every accepted word, indexed by its address field.
  always_ff @(posedge clk) begin
    if (accept) begin
      regfile[shreg[4:0]] <= shreg[31:5];
    end
  end

  // Registered read port and sticky per-address written flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 27'd0;
      written <= 32'h0000_0000;
    end else begin
      rd_data <= regfile[rd_addr];
      if (accept) begin
        written[shreg[4:0]] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uwire_receiver.sv
// Directed bench for uwire_receiver: latency, handshake, overflow, length
// errors, mid-frame reset and a burst of configuration words.
module tb_uwire_receiver;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CLKuWire = 1'b0;
  logic        DATAuWire = 1'b0;
  logic        LEuWire = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] q;
  logic [4:0]  addr;
  logic [26:0] data;
  logic        valid, err_len, err_ovf, busy;
  logic [15:0] word_cnt;
`ifdef UWIRE_RX_REGFILE_EN
  logic [4:0]  rd_addr = 5'd0;
  logic [26:0] rd_data;
  logic [31:0] written;
`endif

  int checks = 0;
  int errors = 0;

  uwire_receiver #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .CLKuWire(CLKuWire), .DATAuWire(DATAuWire), .LEuWire(LEuWire),
    .q(q), .addr(addr), .data(data), .valid(valid), .ready(ready),
    .err_len(err_len), .err_ovf(err_ovf), .busy(busy), .word_cnt(word_cnt)
`ifdef UWIRE_RX_REGFILE_EN
    , .rd_addr(rd_addr), .rd_data(rd_data), .written(written)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      DATAuWire = w[i];
      CLKuWire  = 1'b0;
      repeat (3) @(negedge clk);
      CLKuWire = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  // Raise LE, sample outputs on the cycle before, at and after the expected
  // latch point, then drop LE and let the FSM return to IDLE.
  task automatic do_latch(output logic v_pre, output logic v, output logic el,
                          output logic eo, output logic v_nxt, output logic el_nxt);
    @(negedge clk);
    LEuWire = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 v_pre = valid;
    @(posedge clk);
    #1;
    v  = valid;
    el = err_len;
    eo = err_ovf;
    @(posedge clk);
    #1;
    v_nxt  = valid;
    el_nxt = err_len | err_ovf;
    @(negedge clk);
    CLKuWire = 1'b0;
    repeat (3) @(negedge clk);
    LEuWire = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    CLKuWire = 1'b0;
    LEuWire  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic vp, v, el, eo, vn, en;
    logic [31:0] w;

    do_reset();
    chk("rst_q", q, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_errs", {err_len, err_ovf}, 0);

    // Single word, consumer always ready.
    ready = 1'b1;
    send_bits(64'h80160140, 32);
    chk("busy_shift", busy, 1);
    do_latch(vp, v, el, eo, vn, en);
    chk("lat_pre", vp, 0);
    chk("lat_valid", v, 1);
    chk("lat_noerr", {el, eo}, 0);
    chk("lat_pulse", vn, 0);
    chk("w1_addr", addr, 5'h00);
    chk("w1_data", data, 27'h400B00A);
    chk("w1_cnt", word_cnt, 1);
    chk("busy_idle", busy, 0);

    // Held word, then overflow.
    ready = 1'b0;
    send_bits(64'h914249AA, 32);
    do_latch(vp, v, el, eo, vn, en);
    chk("w2_valid", v, 1);
    chk("w2_hold", vn, 1);
    chk("w2_addr", addr, 5'h0A);
    chk("w2_data", data, 27'h48A124D);
    chk("w2_cnt", word_cnt, 2);
    send_bits(64'h12345678, 32);
    do_latch(vp, v, el, eo, vn, en);
    chk("ovf_pulse", eo, 1);
    chk("ovf_len", el, 0);
    chk("ovf_once", en, 0);
    chk("ovf_q", q, 32'h914249AA);
    chk("ovf_valid", valid, 1);
    chk("ovf_cnt", word_cnt, 2);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 chk("drain_valid", valid, 0);

    // Length errors.
    do_reset();
    send_bits(64'h7FFFFFFF, 31);
    do_latch(vp, v, el, eo, vn, en);
    chk("len31_err", el, 1);
    chk("len31_valid", v, 0);
    chk("len31_once", en, 0);
    send_bits(64'h1_80160140, 33);
    do_latch(vp, v, el, eo, vn, en);
    chk("len33_err", el, 1);
    chk("len33_valid", v, 0);
    chk("len_cnt", word_cnt, 0);

    // Reset in the middle of a frame.
    send_bits(64'h9142, 16);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    send_bits(64'h49AA, 16);
    do_latch(vp, v, el, eo, vn, en);
    chk("mid_err", el, 1);
    chk("mid_valid", v, 0);
    send_bits(64'h80160140, 32);
    do_latch(vp, v, el, eo, vn, en);
    chk("mid_next_valid", v, 1);
    chk("mid_next_q", q, 32'h80160140);
    chk("mid_next_cnt", word_cnt, 1);

    // Burst of 26 configuration words, one per address 0..25.
    do_reset();
    w = 32'h0;
    for (int i = 0; i < 26; i++) begin
      if (i == 10) begin
        w = 32'h914249AA;
      end else begin
        w = {27'h0100000 + 27'(i), 5'(i)};
      end
      send_bits({32'h0, w}, 32);
      do_latch(vp, v, el, eo, vn, en);
    end
    chk("burst_cnt", word_cnt, 26);
    chk("burst_q", q, 32'h02000339);
`ifdef UWIRE_RX_REGFILE_EN
    @(negedge clk);
    rd_addr = 5'h0A;
    @(posedge clk);
    #1 chk("rf_rd_0a", rd_data, 27'h48A124D);
    chk("rf_written", written, 32'h03FFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uwire_receiver.md
UWIRE_RECEIVER -- requirements
Module: uwire_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer flop count on each uWire pin (legal range 2..4).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the accepted-word counter.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port CLKuWire, input, 1 bit: uWire serial clock, asynchronous to clk.
REQ-006 SHALL have port DATAuWire, input, 1 bit: uWire serial data, MSB first.
REQ-007 SHALL have port LEuWire, input, 1 bit: uWire latch enable, asynchronous to clk.
REQ-008 SHALL have port q, output, 32 bits: the last accepted word.
REQ-009 SHALL have port addr, output, 5 bits: q[4:0].
REQ-010 SHALL have port data, output, 27 bits: q[31:5].
REQ-011 SHALL have port valid, output, 1 bit: q/addr/data hold a word not yet consumed.
REQ-012 SHALL have port ready, input, 1 bit: the consumer takes the word on any cycle where valid and ready are both high.
REQ-013 SHALL have port err_len, output, 1 bit: one-cycle pulse when a frame is latched with a bit count other than 32.
REQ-014 SHALL have port err_ovf, output, 1 bit: one-cycle pulse when a good frame is dropped because the output is still occupied.
REQ-015 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.
REQ-016 SHALL have port word_cnt, output, CNT_W bits: accepted-word count, wrapping at its maximum.

Function
REQ-017 SHALL synchronize each uWire pin through SYNC_STAGES flops, then detect edges with one further flop; clk frequency is at least 4x the uWire clock.
REQ-018 SHALL use FSM states IDLE, SHIFT, LATCH and LE_HIGH.
REQ-019 IDLE: on a synchronized CLKuWire rise while LE is low, SHALL shift in DATAuWire, set bit_cnt=1 and go to SHIFT.
REQ-020 SHIFT: each CLKuWire rise SHALL do shreg <= {shreg[30:0], DATAuWire} and increment bit_cnt; bit_cnt is 6 bits and saturates at 63.
REQ-021 From IDLE or SHIFT, a synchronized LE rise SHALL go to LATCH for exactly one cycle.
REQ-022 LATCH, when bit_cnt==32 and (valid==0 or ready==1) this cycle: SHALL load q from shreg, set valid, and increment word_cnt.
REQ-023 LATCH, when bit_cnt==32 and valid==1 and ready==0: SHALL pulse err_ovf and keep the old q.
REQ-024 LATCH, when bit_cnt!=32 (including 0 and more than 32): SHALL pulse err_len and leave q and valid unchanged.
REQ-025 After LATCH, the FSM SHALL enter LE_HIGH and clear bit_cnt; CLKuWire edges in LE_HIGH are ignored, and an LE fall returns the FSM to IDLE.
REQ-026 valid SHALL clear on valid&&ready unless a new word loads in the same cycle, in which case valid stays high with the new q.
REQ-027 Latency SHALL be fixed: valid rises exactly SYNC_STAGES+2 clk cycles after the LEuWire pin rises.
REQ-028 A CLKuWire rise and an LE rise detected in the same cycle SHALL shift the bit first, then evaluate bit_cnt in LATCH.

Reset
REQ-029 On rst_n low, all state SHALL clear asynchronously: FSM=IDLE, q=0, valid=0, err_len=0, err_ovf=0, busy=0, word_cnt=0, bit_cnt=0, and synchronizers to 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the rest of that frame counts as a new frame and yields err_len at its LE.

Configuration
REQ-031 With UWIRE_RX_REGFILE_EN defined, SHALL add a 32x27 shadow register file, written at addr on every accepted word, with ports rd_addr (input, 5 bits), rd_data (output, 27 bits, registered, 1-cycle latency) and written (output, 32 bits, sticky per-address flags).
REQ-032 Without UWIRE_RX_REGFILE_EN, those ports and that storage SHALL not exist, and behaviour is otherwise identical.

Structure
REQ-033 A shared package uwire_pkg SHALL hold UWIRE_WORD_W=32, UWIRE_ADDR_W=5, UWIRE_DATA_W=27 and the FSM state enum.
REQ-034 A sub-module uwire_pin_sync (N-stage synchronizer plus rise/fall detect) SHALL be instantiated once per pin.

Verification
REQ-035 Send 32'h80160140 with ready=1 -> valid pulses 1 cycle, addr=0x00, data=0x400B00A, word_cnt=1, valid at LE+4 clk.
REQ-036 Send 32'h914249AA with ready held 0 -> valid stays 1, addr=0x0A, data=0x48A124D; a second word -> err_ovf pulse, q unchanged.
REQ-037 Frames of 31 and 33 bits -> err_len pulses, valid stays 0, word_cnt=0.
REQ-038 Assert rst_n low after 16 bits, release, send 16 bits plus LE -> err_len; next full word is accepted normally.
REQ-039 Send 26 back-to-back configuration words with ready=1 -> word_cnt=26; with UWIRE_RX_REGFILE_EN, rd_addr=0x0A gives 0x48A124D and written has the expected bits set.
